// File: rtl/sp_ram_bidir.sv
// Single-port synchronous-write RAM with a shared tri-state data bus and an illegal-strobe flag.
// Define RAM_READ_REG_EN for a one-cycle registered read path; the default read is combinational.
module sp_ram_bidir #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              enable,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              write_en;
    logic              drive;
    logic [DATA_W-1:0] rd_data;

    assign write_en = we & ~enable;

    // NOTE: every word must clear on reset, so the array is a register file
    // with a reset loop, not an inferable block RAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep state updates order-independent.
            err <= we & enable;
            if (write_en) begin
                mem[addr] <= data;
            end
        end
    end

`ifdef RAM_READ_REG_EN
    logic              rd_q;
    logic [DATA_W-1:0] dout_q;

    // The captured word predates any write at the same edge, so it returns old data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q   <= 1'b0;
            dout_q <= '0;
        end else begin
            rd_q   <= enable & ~we;
            dout_q <= mem[addr];
        end
    end

    assign drive   = rst_n & rd_q & ~we;
    assign rd_data = dout_q;
`else
    assign drive   = rst_n & enable & ~we;
    assign rd_data = mem[addr];
`endif

    assign data = drive ? rd_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sp_ram_bidir.sv
// Scoreboard bench for sp_ram_bidir: reads push model data, outputs pop and compare.
// Bus release is checked by the host driving a known pattern and reading it back unchanged.
module tb_sp_ram_bidir;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              we;
    logic              enable;
    logic [ADDR_W-1:0] addr;
    logic              err;
    logic              host_oe;
    logic [DATA_W-1:0] host_data;
    wire  [DATA_W-1:0] data;

    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    assign data = host_oe ? host_data : {DATA_W{1'bz}};

    sp_ram_bidir #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .enable (enable),
        .addr   (addr),
        .data   (data),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
        we = 1'b1; enable = 1'b0; addr = a;
        host_oe = 1'b1; host_data = v;
        @(posedge clk); #1;
        model[a] = v;
        we = 1'b0; host_oe = 1'b0;
    endtask

    task automatic read_word(input string tag, input logic [ADDR_W-1:0] a);
        we = 1'b0; enable = 1'b1; addr = a; host_oe = 1'b0;
        exp_q.push_back(model[a]);
`ifdef RAM_READ_REG_EN
        @(posedge clk); #1;
`endif
        @(negedge clk);
        check(tag, data, exp_q.pop_front());
        @(posedge clk); #1;
    endtask

    // Host drives a pattern; any RAM drive would corrupt what the host reads back.
    task automatic check_released(input string tag, input logic [DATA_W-1:0] pattern);
        host_oe = 1'b1; host_data = pattern;
        @(negedge clk);
        check(tag, data, pattern);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; we = 1'b0; enable = 1'b0; addr = '0;
        host_oe = 1'b0; host_data = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_err", err, 1'b0);
        for (int i = 0; i < DEPTH; i++) read_word($sformatf("reset_rd%0d", i), ADDR_W'(i));
        check("reset_err_after_reads", err, 1'b0);

        for (int i = 0; i < DEPTH; i++) write_word(ADDR_W'(i), DATA_W'(i));
        for (int i = 0; i < DEPTH; i++) read_word($sformatf("fill_rd%0d", i), ADDR_W'(i));

        we = 1'b0; enable = 1'b0; addr = 4'd5;
        @(posedge clk); #1;
        check_released("idle_hiz", 8'hC3);
        @(posedge clk); #1;
        host_oe = 1'b0;
        read_word("idle_unchanged", 4'd5);

        write_word(4'd3, 8'hA5);
        we = 1'b1; enable = 1'b1; addr = 4'd3; host_oe = 1'b1; host_data = 8'h5A;
        @(posedge clk); #1;
        check("illegal_err_set", err, 1'b1);
        @(negedge clk);
        check("illegal_hiz", data, 8'h5A);
        @(posedge clk); #1;
        check("illegal_err_held", err, 1'b1);
        host_oe = 1'b0;
        read_word("illegal_no_write", 4'd3);
        check("illegal_err_clear", err, 1'b0);

        rst_n = 1'b0; we = 1'b0; enable = 1'b1; addr = 4'd5;
        check_released("reset_hiz", 8'hA0);
        we = 1'b1; enable = 1'b0; addr = 4'd7; host_oe = 1'b1; host_data = 8'hFF;
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        rst_n = 1'b1; we = 1'b0; host_oe = 1'b0;
        check("midreset_err", err, 1'b0);
        read_word("midreset_rd7", 4'd7);
        read_word("midreset_rd5", 4'd5);

        write_word(4'd15, 8'h11);
        write_word(4'd15, 8'h22);
        write_word(4'd0, 8'h33);
        read_word("wrap_rd15", 4'd15);
        read_word("wrap_rd0", 4'd0);
        read_word("wrap_rd1", 4'd1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
